uart_echo_fifo: RTL and testbench

- Parametrised successor to the single-register UART echo controller.
- Sits between the uart core's receive-side outputs and its transmit-side inputs on the iCE40 top.
- Buffers received bytes in a FIFO and retransmits them in order, honouring the transmitter's busy flag, so back-to-back bytes are not lost.
- Reports fill level, overflow and receive-error counts for LEDs or debug.

---
 rtl/uart_echo_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo
//
// Purpose:
//   Sits between the uart core's receive outputs and its transmit inputs.
//   Received bytes are queued in a FIFO and replayed in order, one transmit
//   request per transmitter busy period, so back-to-back bytes are not lost.
//   Fill level, a sticky overflow flag and a saturating receive-error count
//   are exported for LEDs or debug.
//
// Optional feature (macro UART_ECHO_CASE_FLIP_EN):
//   When defined and DATA_WIDTH == 8, ASCII letters have bit 5 inverted as
//   they are popped (upper <-> lower case). Other values pass unchanged.
//   When undefined, tx_byte is exactly the stored byte.
//
// Ports:
//   clk              in   master clock (uart core domain)
//   rst_n            in   asynchronous active-low reset
//   received         in   strobe: rx_byte valid
//   rx_byte          in   received data word
//   recv_error       in   strobe: framing error on current frame
//   is_transmitting  in   transmitter busy
//   overflow_clr     in   synchronous clear of sticky overflow
//   transmit         out  one-cycle transmit request
//   tx_byte          out  byte to transmit, stable outside IDLE
//   fifo_count       out  occupancy 0..2**FIFO_AW
//   fifo_empty       out  fifo_count == 0
//   fifo_full        out  fifo_count == 2**FIFO_AW
//   overflow         out  sticky: a byte was dropped on a full FIFO
//   err_count        out  saturating count of recv_error strobes
// -----------------------------------------------------------------------------
module uart_echo_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_AW       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  received,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    input  logic                  recv_error,
    input  logic                  is_transmitting,
    input  logic                  overflow_clr,
    output logic                  transmit,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TMR_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(START_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0]      r_wr_ptr;
    logic [FIFO_AW-1:0]      r_rd_ptr;
    logic [FIFO_AW:0]        r_count;
    logic                    r_transmit;
    logic [DATA_WIDTH-1:0]   r_tx_byte;
    logic                    r_overflow;
    logic [ERR_CNT_W-1:0]    r_err_count;
    logic [TMR_W-1:0]        r_timer;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_push_req;
    logic                    w_pop;
    logic                    w_wr_en;
    logic                    w_drop;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_head_x;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = received && !recv_error;
    assign w_pop      = (r_state == S_IDLE) && !w_empty && !is_transmitting;
    // A full FIFO still accepts a byte when a pop frees the head slot in the
    // same cycle; the read sees the old head because the write is registered.
    assign w_wr_en    = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_head     = r_mem[r_rd_ptr];

`ifdef UART_ECHO_CASE_FLIP_EN
    generate
        if (DATA_WIDTH == 8) begin : g_flip
            logic w_is_alpha;
            assign w_is_alpha = ((w_head >= 8'h41) && (w_head <= 8'h5A)) ||
                                ((w_head >= 8'h61) && (w_head <= 8'h7A));
            assign w_head_x   = w_is_alpha ? (w_head ^ 8'h20) : w_head;
        end else begin : g_noflip
            assign w_head_x = w_head;
        end
    endgenerate
`else
    assign w_head_x = w_head;
`endif

    // Storage carries no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)            r_overflow <= 1'b1;
            else if (overflow_clr) r_overflow <= 1'b0;

            if (recv_error && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_transmit <= 1'b0;
            r_tx_byte  <= '0;
            r_timer    <= '0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_byte  <= w_head_x;
                        r_transmit <= 1'b1;
                        r_state    <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    r_timer <= TMR_LOAD;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    // No retry: if the core never reports busy, the byte is
                    // considered sent and the next one may go.
                    if (is_transmitting)    r_state <= S_WAIT_DONE;
                    else if (r_timer == '0) r_state <= S_IDLE;
                    else                    r_timer <= r_timer - 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!is_transmitting) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign transmit   = r_transmit;
    assign tx_byte    = r_tx_byte;
    assign fifo_count = r_count;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_fifo
//
// Directed bench for uart_echo_fifo. Two instances share all inputs: u_a uses
// the default depth (16), u_b uses FIFO_AW=2 (depth 4) for the full/overflow
// scenarios. The transmitter busy flag is driven by hand from the tasks.
// -----------------------------------------------------------------------------
module tb_uart_echo_fifo;

    logic       clk;
    logic       rst_n;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       overflow_clr;

    logic       transmit_a, fifo_empty_a, fifo_full_a, overflow_a;
    logic [7:0] tx_byte_a, err_count_a;
    logic [4:0] fifo_count_a;

    logic       transmit_b, fifo_empty_b, fifo_full_b, overflow_b;
    logic [7:0] tx_byte_b, err_count_b;
    logic [2:0] fifo_count_b;

    int n_cmp = 0;
    int n_bad = 0;

    uart_echo_fifo u_a (
        .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .is_transmitting(is_transmitting),
        .overflow_clr(overflow_clr), .transmit(transmit_a), .tx_byte(tx_byte_a),
        .fifo_count(fifo_count_a), .fifo_empty(fifo_empty_a),
        .fifo_full(fifo_full_a), .overflow(overflow_a), .err_count(err_count_a)
    );

    uart_echo_fifo #(.FIFO_AW(2)) u_b (
        .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .is_transmitting(is_transmitting),
        .overflow_clr(overflow_clr), .transmit(transmit_b), .tx_byte(tx_byte_b),
        .fifo_count(fifo_count_b), .fifo_empty(fifo_empty_b),
        .fifo_full(fifo_full_b), .overflow(overflow_b), .err_count(err_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0;
        is_transmitting = 1'b0; overflow_clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        tick();
        received = 1'b0;
    endtask

    // Wait (bounded) for a transmit pulse on the selected instance, check the
    // byte, then emulate one transmitter busy period.
    task automatic serve_one(input logic [7:0] exp, input bit use_b, input string nm);
        int n = 0;
        while (((use_b ? transmit_b : transmit_a) !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        n_cmp++;
        if ((use_b ? transmit_b : transmit_a) !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: transmit=%b required 1", nm, use_b ? transmit_b : transmit_a);
        end
        n_cmp++;
        if ((use_b ? tx_byte_b : tx_byte_a) !== exp) begin
            n_bad++;
            $display("FAIL %s_byte: tx_byte=%h required %h", nm, use_b ? tx_byte_b : tx_byte_a, exp);
        end
        tick();
        is_transmitting = 1'b1;
        n_cmp++;
        if ((use_b ? transmit_b : transmit_a) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_pulse: transmit=%b required 0", nm, use_b ? transmit_b : transmit_a);
        end
        repeat (3) tick();
        n_cmp++;
        if ((use_b ? transmit_b : transmit_a) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy: transmit=%b required 0", nm, use_b ? transmit_b : transmit_a);
        end
        is_transmitting = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL rst_transmit: %b required 0", transmit_a); end
        n_cmp++; if (tx_byte_a !== 8'h00) begin n_bad++; $display("FAIL rst_tx_byte: %h required 00", tx_byte_a); end
        n_cmp++; if (fifo_count_a !== 5'd0) begin n_bad++; $display("FAIL rst_count: %0d required 0", fifo_count_a); end
        n_cmp++; if (fifo_empty_a !== 1'b1) begin n_bad++; $display("FAIL rst_empty: %b required 1", fifo_empty_a); end
        n_cmp++; if (fifo_full_a !== 1'b0) begin n_bad++; $display("FAIL rst_full: %b required 0", fifo_full_a); end
        n_cmp++; if (overflow_a !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: %b required 0", overflow_a); end
        n_cmp++; if (err_count_a !== 8'd0) begin n_bad++; $display("FAIL rst_err: %0d required 0", err_count_a); end
    endtask

    task automatic test_single();
        do_reset();
        push(8'h41);
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL single_early: transmit=%b required 0", transmit_a); end
        n_cmp++; if (fifo_count_a !== 5'd1) begin n_bad++; $display("FAIL single_count1: %0d required 1", fifo_count_a); end
        tick();
        n_cmp++; if (transmit_a !== 1'b1) begin n_bad++; $display("FAIL single_latency: transmit=%b required 1", transmit_a); end
        n_cmp++; if (tx_byte_a !== 8'h41) begin n_bad++; $display("FAIL single_byte: %h required 41", tx_byte_a); end
        n_cmp++; if (fifo_count_a !== 5'd0) begin n_bad++; $display("FAIL single_count0: %0d required 0", fifo_count_a); end
        tick();
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL single_width: transmit=%b required 0", transmit_a); end
        is_transmitting = 1'b1;
        repeat (3) tick();
        is_transmitting = 1'b0;
        repeat (4) tick();
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL single_empty: transmit=%b required 0", transmit_a); end
    endtask

    task automatic test_burst();
        do_reset();
        is_transmitting = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        tick();
        n_cmp++; if (fifo_count_a !== 5'd5) begin n_bad++; $display("FAIL burst_count: %0d required 5", fifo_count_a); end
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL burst_held: transmit=%b required 0", transmit_a); end
        is_transmitting = 1'b0;
        for (int i = 0; i < 5; i++) serve_one(8'h10 + 8'(i), 1'b0, "burst");
        repeat (4) tick();
        n_cmp++; if (fifo_count_a !== 5'd0) begin n_bad++; $display("FAIL burst_drain: %0d required 0", fifo_count_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        push(8'h55);
        tick();
        n_cmp++; if (transmit_a !== 1'b1) begin n_bad++; $display("FAIL tmo_first: transmit=%b required 1", transmit_a); end
        tick();
        push(8'h56);
        repeat (16) tick();
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL tmo_early: transmit=%b required 0", transmit_a); end
        n_cmp++; if (fifo_count_a !== 5'd1) begin n_bad++; $display("FAIL tmo_count: %0d required 1", fifo_count_a); end
        tick();
        n_cmp++; if (transmit_a !== 1'b1) begin n_bad++; $display("FAIL tmo_second: transmit=%b required 1", transmit_a); end
        n_cmp++; if (tx_byte_a !== 8'h56) begin n_bad++; $display("FAIL tmo_byte: %h required 56", tx_byte_a); end
    endtask

    task automatic test_full();
        do_reset();
        is_transmitting = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        n_cmp++; if (fifo_full_b !== 1'b1) begin n_bad++; $display("FAIL full_flag: %b required 1", fifo_full_b); end
        n_cmp++; if (overflow_b !== 1'b0) begin n_bad++; $display("FAIL full_noovf: %b required 0", overflow_b); end
        push(8'hA4);
        n_cmp++; if (overflow_b !== 1'b1) begin n_bad++; $display("FAIL full_ovf: %b required 1", overflow_b); end
        n_cmp++; if (fifo_count_b !== 3'd4) begin n_bad++; $display("FAIL full_count: %0d required 4", fifo_count_b); end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_cmp++; if (overflow_b !== 1'b0) begin n_bad++; $display("FAIL full_clr: %b required 0", overflow_b); end
        overflow_clr = 1'b1;
        push(8'hA6);
        overflow_clr = 1'b0;
        n_cmp++; if (overflow_b !== 1'b1) begin n_bad++; $display("FAIL full_setwins: %b required 1", overflow_b); end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_cmp++; if (overflow_b !== 1'b0) begin n_bad++; $display("FAIL full_clr2: %b required 0", overflow_b); end
        // Release the transmitter and push in the same cycle as the pop.
        is_transmitting = 1'b0;
        push(8'hA5);
        n_cmp++; if (fifo_count_b !== 3'd4) begin n_bad++; $display("FAIL simul_count: %0d required 4", fifo_count_b); end
        n_cmp++; if (overflow_b !== 1'b0) begin n_bad++; $display("FAIL simul_ovf: %b required 0", overflow_b); end
        n_cmp++; if (tx_byte_b !== 8'hA0) begin n_bad++; $display("FAIL simul_head: %h required a0", tx_byte_b); end
        serve_one(8'hA0, 1'b1, "full0");
        serve_one(8'hA1, 1'b1, "full1");
        serve_one(8'hA2, 1'b1, "full2");
        serve_one(8'hA3, 1'b1, "full3");
        serve_one(8'hA5, 1'b1, "wrap");
        repeat (4) tick();
        n_cmp++; if (fifo_empty_b !== 1'b1) begin n_bad++; $display("FAIL full_drain: empty=%b required 1", fifo_empty_b); end
    endtask

    task automatic test_errors();
        do_reset();
        received = 1'b1; recv_error = 1'b1; rx_byte = 8'h77;
        tick();
        received = 1'b0;
        n_cmp++; if (err_count_a !== 8'd1) begin n_bad++; $display("FAIL err_first: %0d required 1", err_count_a); end
        n_cmp++; if (fifo_count_a !== 5'd0) begin n_bad++; $display("FAIL err_discard: count=%0d required 0", fifo_count_a); end
        repeat (253) tick();
        n_cmp++; if (err_count_a !== 8'd254) begin n_bad++; $display("FAIL err_254: %0d required 254", err_count_a); end
        repeat (46) tick();
        recv_error = 1'b0;
        n_cmp++; if (err_count_a !== 8'd255) begin n_bad++; $display("FAIL err_sat: %0d required 255", err_count_a); end
        n_cmp++; if (fifo_empty_a !== 1'b1) begin n_bad++; $display("FAIL err_empty: %b required 1", fifo_empty_a); end
        tick();
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL err_notx: transmit=%b required 0", transmit_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        is_transmitting = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        is_transmitting = 1'b0;
        tick();
        n_cmp++; if (transmit_a !== 1'b1) begin n_bad++; $display("FAIL mid_pop: transmit=%b required 1", transmit_a); end
        is_transmitting = 1'b1;
        repeat (3) tick();
        n_cmp++; if (fifo_count_a !== 5'd3) begin n_bad++; $display("FAIL mid_count: %0d required 3", fifo_count_a); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_byte_a !== 8'h00) begin n_bad++; $display("FAIL mid_tx_byte: %h required 00", tx_byte_a); end
        n_cmp++; if (fifo_count_a !== 5'd0) begin n_bad++; $display("FAIL mid_rcount: %0d required 0", fifo_count_a); end
        n_cmp++; if (fifo_empty_a !== 1'b1) begin n_bad++; $display("FAIL mid_empty: %b required 1", fifo_empty_a); end
        n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL mid_transmit: %b required 0", transmit_a); end
        rst_n = 1'b1;
        is_transmitting = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (transmit_a !== 1'b0) begin n_bad++; $display("FAIL mid_quiet: transmit=%b required 0", transmit_a); end
        end
    endtask

    task automatic test_case_flip();
        logic [7:0] e61, e7a;
`ifdef UART_ECHO_CASE_FLIP_EN
        e61 = 8'h41; e7a = 8'h5A;
`else
        e61 = 8'h61; e7a = 8'h7A;
`endif
        do_reset();
        push(8'h61); serve_one(e61,   1'b0, "flip61");
        push(8'h31); serve_one(8'h31, 1'b0, "flip31");
        push(8'h7A); serve_one(e7a,   1'b0, "flip7a");
        push(8'h40); serve_one(8'h40, 1'b0, "flip40");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_full();
        test_errors();
        test_reset_mid();
        test_case_flip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
